// File: rtl/gpio_emu_pkg.sv
// Shared constants and helpers for the GPIO-emulation arithmetic peripheral.
package gpio_emu_pkg;

  localparam logic [15:0] OFF_A1   = 16'h0000;
  localparam logic [15:0] OFF_A2   = 16'h0008;
  localparam logic [15:0] OFF_W    = 16'h0010;
  localparam logic [15:0] OFF_L    = 16'h0018;
  localparam logic [15:0] OFF_CTRL = 16'h0020;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned STAT_VALID_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_BUSY_BIT   = 2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StMult  = 2'd1;
  localparam logic [1:0] StCount = 2'd2;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_mul.sv
// Shift-add multiplier: one bit of b_i per clock, OP_WIDTH cycles after start_i.
module seq_mul #(
  parameter int unsigned OP_WIDTH = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [OP_WIDTH-1:0]     a_i,
  input  logic [OP_WIDTH-1:0]     b_i,
  output logic                    done_o,
  output logic [2*OP_WIDTH-1:0]   product_o
);

  localparam int unsigned IdxW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

  logic                  run_q, run_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [2*OP_WIDTH-1:0] acc_q, acc_d;
  logic                  last;

  assign last      = (idx_q == IdxW'(OP_WIDTH - 1));
  // Combinational so the owner can leave MULT on the same edge as the final add.
  assign done_o    = run_q && last;
  assign product_o = acc_q;

  always_comb begin
    run_d = run_q;
    idx_d = idx_q;
    acc_d = acc_q;
    if (start_i) begin
      run_d = 1'b1;
      idx_d = '0;
      acc_d = '0;
    end else if (run_q) begin
      if (b_i[idx_q]) begin
        acc_d = acc_q + ({{OP_WIDTH{1'b0}}, a_i} << idx_q);
      end
      idx_d = idx_q + IdxW'(1);
      if (last) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/gpio_mulcnt_emu.sv
// Bus-mapped multiply-then-popcount peripheral with operation counter and GPIO latch.
module gpio_mulcnt_emu
  import gpio_emu_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = 24,
  parameter int unsigned RES_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  logic [1:0]           state_q, state_d;
  logic [OP_WIDTH-1:0]  a1_q, a1_d, a2_q, a2_d;
  logic [RES_WIDTH-1:0] w_q, w_d;
  logic [5:0]           l_q, l_d;
  logic                 done_q, done_d, valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d, gpio_s_q, gpio_s_d;

  logic sel_a1, sel_a2, sel_w, sel_l, sel_ctrl;
  logic busy, wr_ctrl, start_acc, mul_done, hi_zero;
  logic [2*OP_WIDTH-1:0] product;
  logic [63:0]           acc_ext;
  logic                  unused_sdata;

  assign sel_a1   = (saddress == BASE_ADDR + OFF_A1);
  assign sel_a2   = (saddress == BASE_ADDR + OFF_A2);
  assign sel_w    = (saddress == BASE_ADDR + OFF_W);
  assign sel_l    = (saddress == BASE_ADDR + OFF_L);
  assign sel_ctrl = (saddress == BASE_ADDR + OFF_CTRL);

  assign busy      = (state_q != StIdle);
  assign wr_ctrl   = swr && sel_ctrl;
  assign start_acc = wr_ctrl && sdata_in[CTRL_START_BIT] && !busy;
  assign acc_ext   = 64'(product);
  // Any product bit above the result width means W was truncated.
  assign hi_zero   = ((acc_ext >> RES_WIDTH) == 64'd0);
  assign unused_sdata = ^sdata_in;

  seq_mul #(
    .OP_WIDTH (OP_WIDTH)
  ) u_seq_mul (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (start_acc),
    .a_i       (a1_q),
    .b_i       (a2_q),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    w_d     = w_q;
    l_d     = l_q;
    done_d  = done_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (swr && sel_a1 && !busy) a1_d = sdata_in[OP_WIDTH-1:0];
    if (swr && sel_a2 && !busy) a2_d = sdata_in[OP_WIDTH-1:0];
    case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d = StMult;
          done_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      StMult: begin
        if (mul_done) state_d = StCount;
      end
      StCount: begin
        w_d     = acc_ext[RES_WIDTH-1:0];
        l_d     = popcount(32'(acc_ext[RES_WIDTH-1:0]));
        valid_d = hi_zero;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear takes priority over a coincident completion increment.
    if (wr_ctrl && sdata_in[CTRL_CLEAR_BIT]) cnt_d = '0;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (srd) begin
      rdata_d = '0;
      if (sel_a1)        rdata_d = 32'(a1_q);
      else if (sel_a2)   rdata_d = 32'(a2_q);
      else if (sel_w)    rdata_d = done_q ? 32'(w_q) : 32'd0;
      else if (sel_l)    rdata_d = 32'(l_q);
      else if (sel_ctrl) begin
        rdata_d[STAT_BUSY_BIT]  = busy;
        rdata_d[STAT_DONE_BIT]  = done_q;
        rdata_d[STAT_VALID_BIT] = valid_q;
      end
    end
    gpio_s_d = gpio_latch ? gpio_in : gpio_s_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a1_q     <= '0;
      a2_q     <= '0;
      w_q      <= '0;
      l_q      <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b1;
      cnt_q    <= '0;
      rdata_q  <= '0;
      gpio_s_q <= '0;
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      w_q      <= w_d;
      l_q      <= l_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      gpio_s_q <= gpio_s_d;
    end
  end

  assign sdata_out      = rdata_q;
  assign gpio_out       = 32'(cnt_q);
  assign gpio_in_s_insp = gpio_s_q;

endmodule

// File: tb/tb_gpio_mulcnt_emu.sv
// Directed bench: default-sized instance plus a tiny instance for counter wrap.
module tb_gpio_mulcnt_emu;

  localparam logic [15:0] B = 16'h0380;
  localparam logic [15:0] S = 16'h0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in, sdata_out, gpio_in, gpio_out, gpio_in_s_insp;
  logic        gpio_latch;
  logic [31:0] s_sdata_out, s_gpio_out, s_gpio_insp;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_mulcnt_emu dut (
    .clk            (clk),
    .reset          (reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  gpio_mulcnt_emu #(
    .OP_WIDTH  (4),
    .RES_WIDTH (8),
    .BASE_ADDR (S),
    .CNT_WIDTH (2)
  ) dut_small (
    .clk            (clk),
    .reset          (reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (s_sdata_out),
    .gpio_in        (32'd0),
    .gpio_latch     (1'b0),
    .gpio_out       (s_gpio_out),
    .gpio_in_s_insp (s_gpio_insp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(posedge clk); #1;
    swr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    saddress = a; srd = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    d = (a >= S) ? s_sdata_out : sdata_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Polls STATUS until not busy; n counts the reads that still saw busy.
  task automatic wait_idle(input logic [15:0] ctrl, output int n);
    logic [31:0] st;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      bus_rd(ctrl, st);
      if (!st[2]) break;
      n++;
    end
    check("wait_bound", 32'(n < 60), 32'd1);
  endtask

  logic [31:0] r;
  int n;

  initial begin
    reset = 1'b1; saddress = '0; srd = 1'b0; swr = 1'b0; sdata_in = '0;
    gpio_in = '0; gpio_latch = 1'b0;
    idle(2);
    reset = 1'b0;

    bus_rd(B + 16'h00, r); check("rst_a1", r, 32'h0);
    bus_rd(B + 16'h08, r); check("rst_a2", r, 32'h0);
    bus_rd(B + 16'h10, r); check("rst_w", r, 32'h0);
    bus_rd(B + 16'h18, r); check("rst_l", r, 32'h0);
    bus_rd(B + 16'h20, r); check("rst_status", r, 32'h1);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_insp", gpio_in_s_insp, 32'h0);
    bus_wr(B + 16'h28, 32'hFFFF_FFFF);
    bus_rd(B + 16'h28, r); check("unmapped_rd", r, 32'h0);
    bus_rd(B + 16'h04, r); check("gap_rd", r, 32'h0);

    // 3 * 5, A2 written with junk above OP_WIDTH
    bus_wr(B + 16'h00, 32'd3);
    bus_wr(B + 16'h08, 32'hFF00_0005);
    bus_rd(B + 16'h08, r); check("a2_trunc", r, 32'h5);
    bus_wr(B + 16'h20, 32'h1);
    bus_rd(B + 16'h20, r); check("busy_status", r, 32'h5);
    wait_idle(B + 16'h20, n); check("busy_cycles", 32'(n + 1), 32'd25);
    bus_rd(B + 16'h20, r); check("m1_status", r, 32'h3);
    bus_rd(B + 16'h10, r); check("m1_w", r, 32'hF);
    bus_rd(B + 16'h18, r); check("m1_l", r, 32'd4);
    check("m1_cnt", gpio_out, 32'd1);

    // Full-scale operands overflow 32-bit W
    bus_wr(B + 16'h00, 32'h00FF_FFFF);
    bus_wr(B + 16'h08, 32'h00FF_FFFF);
    bus_wr(B + 16'h20, 32'h1);
    wait_idle(B + 16'h20, n); check("m2_busy", 32'(n), 32'd25);
    bus_rd(B + 16'h20, r); check("m2_status", r, 32'h2);
    bus_rd(B + 16'h10, r); check("m2_w", r, 32'hFE00_0001);
    bus_rd(B + 16'h18, r); check("m2_l", r, 32'd8);
    check("m2_cnt", gpio_out, 32'd2);

    // Writes and restart while busy are ignored
    bus_wr(B + 16'h00, 32'd2);
    bus_wr(B + 16'h08, 32'd3);
    bus_wr(B + 16'h20, 32'h1);
    bus_rd(B + 16'h10, r); check("busy_w_zero", r, 32'h0);
    bus_rd(B + 16'h18, r); check("busy_l_hold", r, 32'd8);
    bus_wr(B + 16'h00, 32'd7);
    bus_wr(B + 16'h20, 32'h1);
    wait_idle(B + 16'h20, n); check("m3_busy", 32'(n), 32'd21);
    bus_rd(B + 16'h10, r); check("m3_w", r, 32'd6);
    bus_rd(B + 16'h18, r); check("m3_l", r, 32'd2);
    bus_rd(B + 16'h00, r); check("m3_a1_kept", r, 32'd2);
    bus_rd(B + 16'h20, r); check("m3_status", r, 32'h3);
    check("m3_cnt", gpio_out, 32'd3);

    // Clear together with start
    bus_wr(B + 16'h20, 32'h3);
    check("clr_cnt", gpio_out, 32'd0);
    wait_idle(B + 16'h20, n); check("clr_busy", 32'(n), 32'd25);
    check("clr_cnt_done", gpio_out, 32'd1);

    // Small instance: truncation, no-overflow product, counter wrap
    bus_wr(S + 16'h00, 32'h1F);
    bus_rd(S + 16'h00, r); check("s_a1_trunc", r, 32'hF);
    bus_wr(S + 16'h08, 32'hF);
    bus_wr(S + 16'h20, 32'h1);
    wait_idle(S + 16'h20, n); check("s_busy", 32'(n), 32'd5);
    bus_rd(S + 16'h10, r); check("s_w", r, 32'hE1);
    bus_rd(S + 16'h18, r); check("s_l", r, 32'd4);
    bus_rd(S + 16'h20, r); check("s_status", r, 32'h3);
    check("s_cnt1", s_gpio_out, 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus_wr(S + 16'h20, 32'h1);
      wait_idle(S + 16'h20, n);
    end
    check("s_cnt_wrap", s_gpio_out, 32'd0);
    // Clear lands on the completion edge
    bus_wr(S + 16'h20, 32'h1);
    idle(4);
    bus_wr(S + 16'h20, 32'h2);
    check("s_clr_collide", s_gpio_out, 32'd0);
    bus_rd(S + 16'h20, r); check("s_collide_status", r, 32'h3);
    bus_wr(S + 16'h20, 32'h3);
    check("s_clr_start", s_gpio_out, 32'd0);
    wait_idle(S + 16'h20, n);
    check("s_clr_start_done", s_gpio_out, 32'd1);

    // Reset in the middle of MULT
    bus_wr(B + 16'h20, 32'h1);
    idle(10);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    bus_rd(B + 16'h20, r); check("abort_status", r, 32'h1);
    bus_rd(B + 16'h10, r); check("abort_w", r, 32'h0);
    bus_rd(B + 16'h00, r); check("abort_a1", r, 32'h0);
    check("abort_cnt", gpio_out, 32'd0);
    idle(30);
    bus_rd(B + 16'h20, r); check("abort_status_late", r, 32'h1);
    check("abort_cnt_late", gpio_out, 32'd0);

    // Simultaneous read and write: read sees pre-edge value
    saddress = B; sdata_in = 32'd9; srd = 1'b1; swr = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0; swr = 1'b0;
    check("rw_pre_edge", sdata_out, 32'h0);
    bus_rd(B, r); check("rw_post", r, 32'd9);

    // GPIO latch
    gpio_in = 32'hA5A5_A5A5;
    idle(1);
    check("insp_no_latch", gpio_in_s_insp, 32'h0);
    gpio_latch = 1'b1;
    idle(1);
    gpio_latch = 1'b0; gpio_in = 32'h0;
    idle(1);
    check("insp_latched", gpio_in_s_insp, 32'hA5A5_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_mulcnt_emu.md
Name: gpio_mulcnt_emu

Overview:
- Bus-mapped arithmetic peripheral on the host register bus (saddress/srd/swr/sdata_in/sdata_out), alongside the GPIO emulation block.
- Computes W = A1 * A2 with a sequential shift-add multiplier, then counts ones (L) in W.
- Reports status, and exports a completed-operation counter and latched GPIO inputs.
- Successor generation: operand/result widths and base address are parameters; fully synchronous; adds busy flag, counter clear, and well-defined busy-time writes.

Parameters:
- OP_WIDTH, 24: operand width, 1..32.
- RES_WIDTH, 32: result register width, 1..32; product truncated to this width.
- BASE_ADDR, 16'h0380: base of the 5-word register map.
- CNT_WIDTH, 16: operation counter width, 1..32.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- saddress  in  16  register address.
- srd  in  1  read strobe, one-cycle level, sampled on rising clk.
- swr  in  1  write strobe, one-cycle level, sampled on rising clk.
- sdata_in  in  32  write data.
- sdata_out  out  32  registered read data.
- gpio_in  in  32  GPIO input pins.
- gpio_latch  in  1  capture gpio_in when high.
- gpio_out  out  32  zero-extended operation counter.
- gpio_in_s_insp  out  32  latched gpio_in.

Behaviour:
- Register map, as offsets from BASE_ADDR:
  - +0x00: A1, RW.
  - +0x08: A2, RW.
  - +0x10: W, RO.
  - +0x18: L, RO.
  - +0x20: CTRL/STATUS. Write: bit0 = start, bit1 = clear counter. Read: {29'b0, busy, done, valid}.
  - All other addresses read 0; writes to them are ignored.
- Reset (synchronous, wins over everything):
  - sdata_out=0, gpio_in_s_insp=0, counter=0.
  - A1=A2=W=L=0, state=IDLE, busy=0, done=0, valid=1.
- Writes:
  - Write to A1/A2 stores sdata_in[OP_WIDTH-1:0].
  - While busy=1, writes to A1/A2 are ignored.
- Start (CTRL write with bit0=1, busy=0):
  - Next edge: busy=1, done=0, valid=1, acc=0, bit index=0, state=MULT.
  - Start while busy=1 is ignored.
- MULT:
  - One operand bit per clock: if A2[i], acc += A1<<i.
  - Runs exactly OP_WIDTH cycles, then state=COUNT.
  - acc is 2*OP_WIDTH bits wide, with no loss.
- COUNT (single cycle):
  - W = acc[RES_WIDTH-1:0].
  - L = popcount(W), zero-extended in the read word.
  - valid = (acc[2*OP_WIDTH-1:RES_WIDTH] == 0); valid is constant 1 when 2*OP_WIDTH <= RES_WIDTH.
  - done=1, busy=0, counter+1, state=IDLE.
- Latency: start sampled on edge 0; W/L/valid/done updated on edge OP_WIDTH+1 (25 for defaults).
- Result holding:
  - W reads return 0 unless done=1.
  - L holds its last value.
  - done stays 1 until the next accepted start.
- Counter:
  - Wraps at all-ones to 0.
  - Clear (bit1) forces it to 0. If clear coincides with an increment, the result is 0.
  - Start and clear in the same write are both honoured.
- Reads:
  - sdata_out updates on the edge where srd=1; it holds otherwise.
  - A read on the same edge as a register update returns the pre-edge value.
  - Simultaneous srd and swr are both executed.
- gpio_in_s_insp <= gpio_in on any edge with gpio_latch=1.
- Reset mid-operation: aborts the operation; done stays 0; the counter does not increment.

Decomposition:
- Shared package gpio_emu_pkg holds:
  - Register offset constants (OFF_A1, OFF_A2, OFF_W, OFF_L, OFF_CTRL).
  - CTRL/STATUS bit index constants.
  - State enum (IDLE, MULT, COUNT).
- One sub-module: seq_mul, the OP_WIDTH-cycle shift-add multiplier with a start/done handshake.
- Popcount is a function in the package.

Test Plan:
- Reset, then read every register → A1/A2/W/L read 0; STATUS reads 0x1; gpio_out=0.
- A1=3, A2=5, start → busy=1 for 25 cycles; STATUS=0x3, W=0xF, L=4; gpio_out=1.
- A1=A2=0xFFFFFF, start → W=0xFE000001, L=8, valid=0 (STATUS=0x2).
- Mid-operation:
  - Write A1=7 while busy → ignored, and the result uses the old A1.
  - Second start while busy → no restart; the counter increments once.
- Clear with start:
  - Counter preloaded to 0xFFFF, start → wraps to 0.
  - CTRL=0x3 → counter 0, then 1 at completion.
- Reset asserted at cycle 10 of MULT → STATUS=0x1, W reads 0, counter 0; gpio_latch pulse with gpio_in=0xA5A5A5A5 → gpio_in_s_insp=0xA5A5A5A5.
